// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_tx. It absorbs clock-rate bursts and drains one byte
// per frame through uart_tx's start/busy handshake.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_en,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow,
    input  logic                clr_ovf,
    output logic [DATA_W-1:0]   tx_data,
    output logic                tx_start,
    input  logic                tx_busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  push;
    logic                  pop;
    logic                  drop;

    assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
    assign rd_idx = rd_ptr[DEPTH_LOG2-1:0];

    // The extra pointer MSB separates full (same index, one lap apart) from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_idx == rd_idx) && (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
    assign count = wr_ptr - rd_ptr;

    // tx_start depends only on registered pointers, so uart_tx never sees a
    // combinational path back from its own busy output or from the producer.
    assign tx_start = ~empty;
    assign tx_data  = tx_start ? mem[rd_idx] : '0;

    // A write while full is dropped even if a pop frees a slot on the same edge.
    assign push = wr_en & ~full;
    assign drop = wr_en & full;
    assign pop  = tx_start & ~tx_busy;

    // NOTE: sequential state uses non-blocking assignments so every process sees
    // the pre-edge values of the pointers and flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; stale entries are never visible
    // because tx_data is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= wr_data;
    end

endmodule
